// File: rtl/sccb_reg_writer.sv
// SCCB single-register write master: one ID/register/data write on open-drain scl/sda,
// followed by a bus-free gap before the next start request is accepted.
module sccb_reg_writer #(
    parameter int unsigned QTR_CYCLES = 250,
    parameter int unsigned BUF_QTRS   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] write_id,
    input  logic [7:0] write_reg,
    input  logic [7:0] write_data,
    output logic       done,
    output logic       busy,
    output logic       ack_error,
    inout  wire        scl,
    inout  wire        sda
);
    localparam int unsigned QTR_W = $clog2(QTR_CYCLES);
    localparam int unsigned QIX_W = $clog2(BUF_QTRS);
    localparam int unsigned BIT_W = 5;
    localparam int unsigned SR_W  = 24;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START_A = 3'd1;
    localparam logic [2:0] S_START_B = 3'd2;
    localparam logic [2:0] S_BIT     = 3'd3;
    localparam logic [2:0] S_STOP_A  = 3'd4;
    localparam logic [2:0] S_STOP_B  = 3'd5;
    localparam logic [2:0] S_STOP_C  = 3'd6;
    localparam logic [2:0] S_GAP     = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [QTR_W-1:0] qtr_q, qtr_d;
    logic [QIX_W-1:0] qix_q, qix_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [SR_W-1:0]  shreg_q, shreg_d;
    logic             ack_error_q, ack_error_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             scl_low_q, scl_low_d;
    logic             sda_low_q, sda_low_d;
    logic             qtr_last;
    logic             sda_in;

    assign sda_in = sda;

    // Ninth bit of each byte is the slave's don't-care/ack slot
    function automatic logic is_ack(input logic [BIT_W-1:0] b);
        return (b == BIT_W'(8)) || (b == BIT_W'(17)) || (b == BIT_W'(26));
    endfunction

    always_comb begin
        state_d     = state_q;
        qtr_d       = qtr_q;
        qix_d       = qix_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        ack_error_d = ack_error_q;
        qtr_last    = (qtr_q == QTR_W'(QTR_CYCLES - 1));

        if (state_q != S_IDLE) begin
            qtr_d = qtr_last ? '0 : qtr_q + QTR_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d     = {write_id, write_reg, write_data};
                    ack_error_d = 1'b0;
                    state_d     = S_START_A;
                end
            end
            S_START_A: if (qtr_last) state_d = S_START_B;
            S_START_B: begin
                if (qtr_last) begin
                    state_d = S_BIT;
                    qix_d   = '0;
                    bit_d   = '0;
                end
            end
            S_BIT: begin
                if (qtr_last) begin
                    qix_d = qix_q + QIX_W'(1);
                    if (qix_q == QIX_W'(2) && is_ack(bit_q) && sda_in) begin
                        ack_error_d = 1'b1;
                    end
                    if (qix_q == QIX_W'(3)) begin
                        qix_d = '0;
                        if (!is_ack(bit_q)) shreg_d = {shreg_q[SR_W-2:0], 1'b0};
                        if (bit_q == BIT_W'(26)) state_d = S_STOP_A;
                        else                     bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            S_STOP_A: if (qtr_last) state_d = S_STOP_B;
            S_STOP_B: if (qtr_last) state_d = S_STOP_C;
            S_STOP_C: begin
                if (qtr_last) begin
                    state_d = S_GAP;
                    qix_d   = '0;
                end
            end
            S_GAP: begin
                if (qtr_last) begin
                    if (qix_q == QIX_W'(BUF_QTRS - 1)) begin
                        state_d = S_IDLE;
                        qix_d   = '0;
                    end else begin
                        qix_d = qix_q + QIX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pin drives follow the next state so the pins change together with the state
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
        case (state_d)
            S_START_A: sda_low_d = 1'b1;
            S_START_B, S_STOP_A: begin
                scl_low_d = 1'b1;
                sda_low_d = 1'b1;
            end
            S_STOP_B: sda_low_d = 1'b1;
            S_BIT: begin
                scl_low_d = ~qix_d[1];
                sda_low_d = ~is_ack(bit_d) & ~shreg_d[SR_W-1];
            end
            default: ;
        endcase

        done_d = (state_d == S_STOP_C) && (qtr_d == QTR_W'(QTR_CYCLES - 1));
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            qtr_q       <= '0;
            qix_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            ack_error_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            scl_low_q   <= 1'b0;
            sda_low_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            qtr_q       <= qtr_d;
            qix_q       <= qix_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            ack_error_q <= ack_error_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            scl_low_q   <= scl_low_d;
            sda_low_q   <= sda_low_d;
        end
    end

    assign scl       = scl_low_q ? 1'b0 : 1'bz;
    assign sda       = sda_low_q ? 1'b0 : 1'bz;
    assign done      = done_q;
    assign busy      = busy_q;
    assign ack_error = ack_error_q;

endmodule

// File: tb/tb_sccb_reg_writer.sv
// Directed bench for sccb_reg_writer: SCCB slave model with pullups, timing and protocol checks.
module tb_sccb_reg_writer;
    localparam int unsigned QTR  = 4;
    localparam int unsigned BUFQ = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] write_id = 8'h00;
    logic [7:0] write_reg = 8'h00;
    logic [7:0] write_data = 8'h00;
    logic       done;
    logic       busy;
    logic       ack_error;
    wire        scl_w;
    wire        sda_w;

    logic       slave_drv = 1'b0;
    bit         ack_en = 1'b1;

    pullup (scl_w);
    pullup (sda_w);
    assign sda_w = slave_drv ? 1'b0 : 1'bz;

    sccb_reg_writer #(.QTR_CYCLES(QTR), .BUF_QTRS(BUFQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .write_id  (write_id),
        .write_reg (write_reg),
        .write_data(write_data),
        .done      (done),
        .busy      (busy),
        .ack_error (ack_error),
        .scl       (scl_w),
        .sda       (sda_w)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Bus monitor / slave model state
    bit          mon_en = 1'b0;
    logic        scl_p = 1'b1;
    logic        sda_p = 1'b1;
    bit          in_frame = 1'b0;
    int          rise_cnt = 0;
    logic [23:0] frame = '0;
    logic [23:0] frames[$];
    bit          ack_pend = 1'b0;
    bit          ack_act = 1'b0;
    int          abandoned = 0;
    int          mon_bad = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if ($isunknown({scl_w, sda_w})) begin
                mon_bad++;
                $display("FAIL bus_level cyc=%0d scl=%b sda=%b, required 0/1 only", cyc, scl_w, sda_w);
            end else if (scl_p && scl_w && sda_p && !sda_w) begin
                if (in_frame) abandoned++;
                in_frame  = 1'b1;
                rise_cnt  = 0;
                frame     = '0;
                slave_drv = 1'b0;
                ack_pend  = 1'b0;
                ack_act   = 1'b0;
            end else if (scl_p && scl_w && !sda_p && sda_w) begin
                if (in_frame && rise_cnt == 28) begin
                    frames.push_back(frame);
                end else begin
                    mon_bad++;
                    $display("FAIL stop_position cyc=%0d scl_rises=%0d in_frame=%0d, required 28 rises in a frame",
                             cyc, rise_cnt, in_frame);
                end
                in_frame = 1'b0;
            end else if (in_frame && !scl_p && scl_w) begin
                if (rise_cnt < 27 && (rise_cnt % 9) != 8) frame = {frame[22:0], sda_w};
                if (rise_cnt < 27 && (rise_cnt % 9) == 7) ack_pend = 1'b1;
                rise_cnt++;
            end else if (in_frame && scl_p && !scl_w) begin
                if (ack_act) begin
                    slave_drv = 1'b0;
                    ack_act   = 1'b0;
                end else if (ack_pend) begin
                    slave_drv = ack_en;
                    ack_act   = 1'b1;
                    ack_pend  = 1'b0;
                end
            end
            if (done === 1'b1) done_cnt++;
        end
        scl_p = scl_w;
        sda_p = sda_w;
    end

    task automatic wait_for(input bit use_done, input logic val, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((use_done ? done : busy) === val) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic launch(input logic [7:0] i, input logic [7:0] r, input logic [7:0] d, output int t);
        bit ok;
        wait_for(1'b0, 1'b0, 2000, ok);
        write_id   = i;
        write_reg  = r;
        write_data = d;
        start      = 1'b1;
        t          = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        checks++; if (scl_w !== 1'b1) begin errors++; $display("FAIL reset_scl got=%b exp=1", scl_w); end
        checks++; if (sda_w !== 1'b1) begin errors++; $display("FAIL reset_sda got=%b exp=1", sda_w); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ack_error !== 1'b0) begin errors++; $display("FAIL reset_ack_error got=%b exp=0", ack_error); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_write;
        int t;
        bit ok;
        logic [23:0] f;
        ack_en = 1'b1;
        frames.delete();
        launch(8'h42, 8'h12, 8'h80, t);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got=%b exp=1", busy); end
        wait_for(1'b1, 1'b1, 1000, ok);
        checks++; if (!ok || (cyc - t) != 452) begin
            errors++; $display("FAIL basic_done_time got=%0d exp=452 (found=%0d)", cyc - t, ok);
        end
        checks++; if (ack_error !== 1'b0) begin errors++; $display("FAIL basic_ack_error got=%b exp=0", ack_error); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b exp=0", done); end
        wait_for(1'b0, 1'b0, 1000, ok);
        checks++; if (!ok || (cyc - t) != 485) begin
            errors++; $display("FAIL basic_busy_fall got=%0d exp=485 (found=%0d)", cyc - t, ok);
        end
        f = (frames.size() > 0) ? frames[0] : 24'hxxxxxx;
        checks++; if (frames.size() != 1 || f !== 24'h421280) begin
            errors++; $display("FAIL basic_frame got=%h count=%0d exp=421280 count=1", f, frames.size());
        end
    endtask

    task automatic test_back_to_back;
        int t1, t2, n;
        bit ok;
        ack_en = 1'b1;
        frames.delete();
        wait_for(1'b0, 1'b0, 2000, ok);
        write_id = 8'h42; write_reg = 8'h40; write_data = 8'hD0;
        start = 1'b1;
        t1 = cyc;
        @(negedge clk);
        wait_for(1'b1, 1'b1, 1000, ok);
        @(negedge clk);
        write_reg = 8'h1E; write_data = 8'h10;
        wait_for(1'b0, 1'b0, 1000, ok);
        wait_for(1'b0, 1'b1, 20, ok);
        t2 = cyc - 1;
        // One IDLE cycle separates the end of the gap from the next launch
        checks++; if (!ok || (t2 - t1) != 485) begin
            errors++; $display("FAIL level_launch_spacing got=%0d exp=485 (found=%0d)", t2 - t1, ok);
        end
        wait_for(1'b1, 1'b1, 1000, ok);
        @(negedge clk);
        start = 1'b0;
        wait_for(1'b0, 1'b0, 1000, ok);
        repeat (20) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL level_no_third got=%b exp=0", busy); end
        n = frames.size();
        checks++; if (n != 2 || frames[0] !== 24'h4240D0 || frames[1] !== 24'h421E10) begin
            errors++;
            $display("FAIL level_frames count=%0d first=%h second=%h exp 2: 4240d0 421e10",
                     n, (n > 0) ? frames[0] : 24'h0, (n > 1) ? frames[1] : 24'h0);
        end
    endtask

    task automatic test_no_slave;
        int t, d0;
        bit ok;
        logic [23:0] f;
        ack_en = 1'b0;
        frames.delete();
        d0 = done_cnt;
        launch(8'h42, 8'hB0, 8'h84, t);
        wait_for(1'b1, 1'b1, 1000, ok);
        checks++; if (!ok || ack_error !== 1'b1) begin
            errors++; $display("FAIL noslave_ack_error got=%b exp=1 (found=%0d)", ack_error, ok);
        end
        wait_for(1'b0, 1'b0, 1000, ok);
        repeat (2) @(negedge clk);
        checks++; if ((done_cnt - d0) != 1) begin
            errors++; $display("FAIL noslave_done_count got=%0d exp=1", done_cnt - d0);
        end
        f = (frames.size() > 0) ? frames[0] : 24'hxxxxxx;
        checks++; if (frames.size() != 1 || f !== 24'h42B084) begin
            errors++; $display("FAIL noslave_frame got=%h count=%0d exp=42b084 count=1", f, frames.size());
        end
        checks++; if (ack_error !== 1'b1) begin errors++; $display("FAIL noslave_ack_hold got=%b exp=1", ack_error); end
        ack_en = 1'b1;
    endtask

    task automatic test_ignored_start;
        int t, d0;
        bit ok;
        logic [23:0] f;
        ack_en = 1'b1;
        frames.delete();
        d0 = done_cnt;
        launch(8'h42, 8'h3A, 8'h04, t);
        while (cyc < t + 100) @(negedge clk);
        write_id = 8'hFF; write_reg = 8'hFF; write_data = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t + 470) @(negedge clk);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL ignored_in_gap busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_for(1'b0, 1'b0, 1000, ok);
        repeat (40) @(negedge clk);
        checks++; if (busy !== 1'b0 || (done_cnt - d0) != 1) begin
            errors++; $display("FAIL ignored_extra busy=%b dones=%0d exp busy=0 dones=1", busy, done_cnt - d0);
        end
        f = (frames.size() > 0) ? frames[0] : 24'hxxxxxx;
        checks++; if (frames.size() != 1 || f !== 24'h423A04) begin
            errors++; $display("FAIL ignored_frame got=%h count=%0d exp=423a04 count=1", f, frames.size());
        end
    endtask

    task automatic test_reset_mid;
        int t, d0;
        bit ok;
        logic [23:0] f;
        ack_en = 1'b1;
        frames.delete();
        launch(8'h42, 8'h8C, 8'h55, t);
        // bit 13, second quarter (scl low)
        while (cyc < t + 221) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (scl_w !== 1'b1 || sda_w !== 1'b1) begin
            errors++; $display("FAIL midreset_bus scl=%b sda=%b exp both released", scl_w, sda_w);
        end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midreset_flags busy=%b done=%b exp 0 0", busy, done);
        end
        reset = 1'b0;
        d0 = done_cnt;
        repeat (500) @(negedge clk);
        checks++; if (done_cnt != d0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_no_done dones=%0d busy=%b exp 0 0", done_cnt - d0, busy);
        end
        launch(8'h42, 8'h11, 8'h22, t);
        wait_for(1'b1, 1'b1, 1000, ok);
        checks++; if (!ok || (cyc - t) != 452 || ack_error !== 1'b0) begin
            errors++; $display("FAIL midreset_recover dt=%0d ack_error=%b exp 452 0", cyc - t, ack_error);
        end
        wait_for(1'b0, 1'b0, 1000, ok);
        f = (frames.size() > 0) ? frames[0] : 24'hxxxxxx;
        checks++; if (frames.size() != 1 || f !== 24'h421122) begin
            errors++; $display("FAIL midreset_frame got=%h count=%0d exp=421122 count=1", f, frames.size());
        end
    endtask

    task automatic test_protocol;
        checks++; if (mon_bad != 0) begin errors++; $display("FAIL protocol_violations got=%0d exp=0", mon_bad); end
        checks++; if (abandoned != 1) begin errors++; $display("FAIL protocol_abandoned got=%0d exp=1", abandoned); end
    endtask

    initial begin
        test_reset;
        test_basic_write;
        test_back_to_back;
        test_no_slave;
        test_ignored_start;
        test_reset_mid;
        test_protocol;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
